// File: rtl/commutator_postdelay_pkg.sv
// Shared FFT pipeline types: default sample width, complex sample and commutator phase.
package commutator_postdelay_pkg;

    localparam int FFT_DATA_W = 16;

    typedef struct packed {
        logic signed [FFT_DATA_W-1:0] re;
        logic signed [FFT_DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        PASS = 1'b0,
        SWAP = 1'b1
    } phase_e;

endpackage

// File: rtl/commutator_postdelay_if.sv
// Two-path complex sample bus into and out of the R2MDC switch-and-align stage.
interface commutator_postdelay_if
    import commutator_postdelay_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] in0_re;
    logic signed [DATA_W-1:0] in0_im;
    logic signed [DATA_W-1:0] in1_re;
    logic signed [DATA_W-1:0] in1_im;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out0_re;
    logic signed [DATA_W-1:0] out0_im;
    logic signed [DATA_W-1:0] out1_re;
    logic signed [DATA_W-1:0] out1_im;

    modport master (
        output in_valid, in0_re, in0_im, in1_re, in1_im,
        input  out_valid, out0_re, out0_im, out1_re, out1_im
    );

    modport slave (
        input  in_valid, in0_re, in0_im, in1_re, in1_im,
        output out_valid, out0_re, out0_im, out1_re, out1_im
    );

endinterface

// File: rtl/commutator_postdelay_delay_ram.sv
// Read-before-write circular delay buffer; rdata shows the entry's old contents
// in the same cycle the new word is written.
module delay_ram #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Contents are never reset; the caller masks stale words with its own fill count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/commutator_postdelay.sv
// R2MDC switch-and-align stage: swaps the two paths every DELAY_CYCLES valid
// samples and delays the switched upper path by DELAY_CYCLES valid samples.
module commutator_postdelay
    import commutator_postdelay_pkg::*;
#(
    parameter int DELAY_CYCLES = 16,
    parameter int DATA_W       = FFT_DATA_W
) (
    input logic                   CLK,
    input logic                   RST,
    commutator_postdelay_if.slave bus
);

    localparam int                CNT_W     = $clog2(DELAY_CYCLES);
    localparam int                FILL_W    = $clog2(DELAY_CYCLES + 1);
    localparam int                WORD_W    = 2 * DATA_W;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DELAY_CYCLES);

    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    phase_e            phase_q, phase_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out0_q, out0_d;
    logic [WORD_W-1:0] out1_q, out1_d;
    logic [WORD_W-1:0] in0_w, in1_w, sw0, sw1, ram_rdata;

    assign in0_w = {bus.in0_re, bus.in0_im};
    assign in1_w = {bus.in1_re, bus.in1_im};

    always_comb begin
        sw0 = in0_w;
        sw1 = in1_w;
        if (phase_q == SWAP) begin
            sw0 = in1_w;
            sw1 = in0_w;
        end
    end

    delay_ram #(
        .DEPTH (DELAY_CYCLES),
        .WIDTH (WORD_W)
    ) u_delay_ram (
        .clk   (CLK),
        .we    (bus.in_valid),
        .addr  (sample_cnt_q),
        .wdata (sw0),
        .rdata (ram_rdata)
    );

    // Everything advances on valid samples only, so input gaps are transparent.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        phase_d      = phase_q;
        fill_cnt_d   = fill_cnt_q;
        out_valid_d  = 1'b0;
        out0_d       = out0_q;
        out1_d       = out1_q;
        if (bus.in_valid) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (sample_cnt_q == CNT_LAST) begin
                phase_d = (phase_q == PASS) ? SWAP : PASS;
            end
            if (fill_cnt_q != FILL_FULL) begin
                fill_cnt_d = fill_cnt_q + FILL_W'(1);
            end
            out0_d      = ram_rdata;
            out1_d      = sw1;
            out_valid_d = (fill_cnt_q == FILL_FULL);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sample_cnt_q <= '0;
            phase_q      <= PASS;
            fill_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out0_q       <= '0;
            out1_q       <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            phase_q      <= phase_d;
            fill_cnt_q   <= fill_cnt_d;
            out_valid_q  <= out_valid_d;
            out0_q       <= out0_d;
            out1_q       <= out1_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out0_re   = out0_q[WORD_W-1:DATA_W];
    assign bus.out0_im   = out0_q[DATA_W-1:0];
    assign bus.out1_re   = out1_q[WORD_W-1:DATA_W];
    assign bus.out1_im   = out1_q[DATA_W-1:0];

endmodule

// File: tb/tb_commutator_postdelay.sv
// Directed bench for commutator_postdelay at D = 4 and D = 2 with hand-computed beats.
module tb_commutator_postdelay;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    commutator_postdelay_if #(.DATA_W(16)) bus4 ();
    commutator_postdelay_if #(.DATA_W(16)) bus2 ();

    commutator_postdelay #(.DELAY_CYCLES(4), .DATA_W(16)) dut4 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus4)
    );

    commutator_postdelay #(.DELAY_CYCLES(2), .DATA_W(16)) dut2 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int exp0_tab [8] = '{0, 1, 2, 3, 104, 105, 106, 107};
    int exp1_tab [8] = '{4, 5, 6, 7, 108, 109, 110, 111};

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive4(input logic v, input int a, input int b, input int ai, input int bi);
        bus4.in_valid = v;
        bus4.in0_re = 16'(a);
        bus4.in1_re = 16'(b);
        bus4.in0_im = 16'(ai);
        bus4.in1_im = 16'(bi);
    endtask

    task automatic drive2(input logic v, input int a, input int b);
        bus2.in_valid = v;
        bus2.in0_re = 16'(a);
        bus2.in1_re = 16'(b);
        bus2.in0_im = 16'(a + 1000);
        bus2.in1_im = 16'(b + 1000);
    endtask

    task automatic do_reset();
        drive4(1'b0, 0, 0, 0, 0);
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic check_beat4(input string tag, input int e0, input int e1);
        check({tag, "_vld"}, bus4.out_valid, 1);
        check({tag, "_out0_re"}, bus4.out0_re, e0);
        check({tag, "_out0_im"}, bus4.out0_im, e0 + 1000);
        check({tag, "_out1_re"}, bus4.out1_re, e1);
        check({tag, "_out1_im"}, bus4.out1_im, e1 + 1000);
    endtask

    task automatic run_pairing(input string tag, input bit gapped, input int last_k);
        for (int k = 0; k <= last_k; k++) begin
            drive4(1'b1, k, 100 + k, 1000 + k, 1100 + k);
            tick();
            if (k >= 4) check_beat4($sformatf("%s_k%0d", tag, k), exp0_tab[k-4], exp1_tab[k-4]);
            else check($sformatf("%s_prime_k%0d", tag, k), bus4.out_valid, 0);
            if (gapped) begin
                drive4(1'b0, 777, 888, 555, 666);
                tick();
                check($sformatf("%s_gap_vld_k%0d", tag, k), bus4.out_valid, 0);
                if (k >= 4) begin
                    check($sformatf("%s_gap_hold0_k%0d", tag, k), bus4.out0_re, exp0_tab[k-4]);
                    check($sformatf("%s_gap_hold1_k%0d", tag, k), bus4.out1_im, exp1_tab[k-4] + 1000);
                end
            end
        end
        drive4(1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1;
        drive4(1'b0, 0, 0, 0, 0);
        drive2(1'b0, 0, 0);
        tick();
        tick();
        RST = 1'b0;
        tick();

        check("rst_vld4", bus4.out_valid, 0);
        check("rst_out0_re", bus4.out0_re, 0);
        check("rst_out1_im", bus4.out1_im, 0);
        check("rst_vld2", bus2.out_valid, 0);

        // Mid-stream zero samples fill every buffer entry, then reset and re-prime.
        for (int k = 0; k < 6; k++) begin
            drive4(1'b1, 0, 0, 0, 0);
            tick();
        end
        check("prestream_vld", bus4.out_valid, 1);
        drive4(1'b0, 0, 0, 0, 0);
        #2 RST = 1'b1;
        #1;
        check("midrst_vld", bus4.out_valid, 0);
        tick();
        RST = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            drive4(1'b1, 0, 0, 0, 0);
            tick();
            check($sformatf("prime_vld_k%0d", k), bus4.out_valid, 0);
            check($sformatf("prime_out0_re_k%0d", k), bus4.out0_re, 0);
            check($sformatf("prime_out0_im_k%0d", k), bus4.out0_im, 0);
            check($sformatf("prime_out1_re_k%0d", k), bus4.out1_re, 0);
            check($sformatf("prime_out1_im_k%0d", k), bus4.out1_im, 0);
        end

        do_reset();
        run_pairing("basic", 1'b0, 11);

        do_reset();
        run_pairing("gap", 1'b1, 11);

        // Phase wrap over 4D samples: PASS 0-3, SWAP 4-7, PASS 8-11, SWAP 12-15.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive4(1'b1, k, 100 + k, 1000 + k, 1100 + k);
            tick();
            if (k >= 4) begin
                check_beat4($sformatf("wrap_k%0d", k),
                            (((k - 4) / 4) % 2 == 1) ? 100 + k - 4 : k - 4,
                            ((k / 4) % 2 == 1) ? k : 100 + k);
            end
        end
        drive4(1'b0, 0, 0, 0, 0);

        // Async reset between edges after sample 6, then a clean restart.
        do_reset();
        run_pairing("pre_async", 1'b0, 6);
        #2 RST = 1'b1;
        #1;
        check("async_vld", bus4.out_valid, 0);
        check("async_out0_re", bus4.out0_re, 0);
        check("async_out1_re", bus4.out1_re, 0);
        check("async_out1_im", bus4.out1_im, 0);
        tick();
        RST = 1'b0;
        tick();
        run_pairing("restart", 1'b0, 11);

        // D = 2 instance.
        do_reset();
        begin
            int e0 [4] = '{0, 1, 52, 53};
            int e1 [4] = '{2, 3, 54, 55};
            for (int k = 0; k < 6; k++) begin
                drive2(1'b1, k, 50 + k);
                tick();
                if (k >= 2) begin
                    check($sformatf("d2_vld_k%0d", k), bus2.out_valid, 1);
                    check($sformatf("d2_out0_re_k%0d", k), bus2.out0_re, e0[k-2]);
                    check($sformatf("d2_out0_im_k%0d", k), bus2.out0_im, e0[k-2] + 1000);
                    check($sformatf("d2_out1_re_k%0d", k), bus2.out1_re, e1[k-2]);
                    check($sformatf("d2_out1_im_k%0d", k), bus2.out1_im, e1[k-2] + 1000);
                end else begin
                    check($sformatf("d2_prime_k%0d", k), bus2.out_valid, 0);
                end
            end
            drive2(1'b0, 0, 0);
            tick();
            check("d2_idle_vld", bus2.out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
